omux_arbiter: RTL and testbench
===============================

# omux_arbiter

Round-robin arbiter and byte sequencer for the shared `omux` output bus. It sits between up to NREQ record_buffer instances and the single host byte FIFO. It grants the bus to one requester for exactly one whole record, strobes that requester's `omux_sel_i` one byte at a time while the sink has room, and forwards the bytes with a start-of-record marker. It also inserts the hold-off gap each requester needs to load its next record.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `RECORD_BYTES`, 16: bytes per record; equals requester record width / 8.
- `GAP_CYCLES`, 2: idle cycles after the last byte of a record before re-arbitration (≥2).
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: allow new grants. The record in flight always completes.
- `mask_i` in NREQ: per-requester enable; a requester whose bit is 0 is never granted.
- `omux_req_i` in NREQ: request vector, bit i from requester i's `omux_req_o`.
- `omux_sel_o` out NREQ: one-hot byte strobe to requester i's `omux_sel_i`.
- `omux_data_i` in 8: shared byte bus, driven only by the selected requester.
- `out_full_i` in 1: sink FIFO full.
- `out_we_o` out 1: sink write strobe.
- `out_data_o` out 8: byte to sink.
- `out_sor_o` out 1: first byte of a record, qualified by `out_we_o`.
- `busy_o` out 1: high when the state is not IDLE.
- `rec_count_o` out 32: completed records; wraps modulo 2^32.
- `trunc_count_o` out 16: aborted records; saturates at 0xFFFF.

## Operation
- Registers: `state` ∈ {IDLE, XFER, GAP}; `grant` ($clog2(NREQ) bits); `last_grant`; `byte_cnt` ($clog2(RECORD_BYTES)+1 bits); `gap_cnt`.
- Reset:
  - `state`=IDLE, `last_grant`=NREQ-1, so requester 0 has first priority.
  - Counters are 0.
  - All outputs are 0.
- Reset mid-transfer drops the record silently and does not count it as truncated.
- Eligible requesters: `omux_req_i & mask_i`.
- IDLE:
  - If `enable_i` and any requester is eligible, set `grant` to the first eligible index searching (last_grant+1) mod NREQ upward with wrap.
  - Then set `last_grant`=`grant`, `byte_cnt`=0, and go to XFER.
- XFER:
  - `omux_sel_o[grant]` = `omux_req_i[grant]` & ~`out_full_i`. This is combinational; all other bits are 0.
  - Each strobe cycle increments `byte_cnt`.
  - On a strobe with `byte_cnt`==RECORD_BYTES-1: increment `rec_count_o`, set `gap_cnt`=0, go to GAP.
  - If `omux_req_i[grant]` is low:
    - `byte_cnt`≠0: increment `trunc_count_o` (saturating) and go to IDLE.
    - `byte_cnt`==0: go to IDLE without counting.
- GAP: `omux_sel_o`=0. Go to IDLE after GAP_CYCLES cycles, counted by `gap_cnt`.
- `mask_i` and `enable_i` are sampled only in IDLE. Deasserting either during XFER does not cut the record.
- Requests from non-granted requesters during XFER or GAP have no effect until IDLE.
- `out_full_i` during XFER stalls the strobes. There is no timeout; `byte_cnt` holds.

## Timing
- Output path is registered with 1-cycle latency:
  - `out_we_o` <= |`omux_sel_o`.
  - `out_data_o` <= `omux_data_i` when a strobe is active; otherwise it holds.
  - `out_sor_o` <= strobe & (`byte_cnt`==0).
- Grant latency:
  - Request visible in IDLE at cycle t.
  - First strobe at t+1, when the sink is not full.
  - First byte on `out_*` at t+2.
- A full record takes RECORD_BYTES consecutive strobe cycles when `out_full_i` stays low.
- The last strobe at cycle k is followed by GAP at k+1..k+GAP_CYCLES, IDLE at k+GAP_CYCLES+1, and the next strobe at k+GAP_CYCLES+2.
- The minimum GAP_CYCLES=2 covers the requester's reload: end-of-record detect → load → byte 0 valid.
- The sink must accept a write in the cycle after it deasserted `out_full_i`. `out_full_i` gates only strobe generation, not the registered write.

## Test plan
- Single requester 0, RECORD_BYTES=16, bytes 0x00..0x0F, sink never full:
  - 16 `out_we_o` pulses, data 0x00..0x0F, `out_sor_o` on the first only.
  - `rec_count_o`=1.
  - Next record's first strobe exactly GAP_CYCLES+2 cycles after the last.
- All 4 requesters requesting continuously:
  - Grant order 0,1,2,3,0,…
  - Each burst is exactly 16 bytes.
  - Never two `omux_sel_o` bits high.
- `out_full_i` pulsed high for 3 cycles at byte 5:
  - Strobes pause for 3 cycles.
  - No byte lost or duplicated; output is still 0x00..0x0F.
- Requester 2 drops `omux_req_i` after 7 bytes:
  - `trunc_count_o`=1, `rec_count_o` unchanged.
  - Arbiter returns to IDLE and next grants requester 3.
- `enable_i` deasserted at byte 4 of a record:
  - Record completes (16 bytes).
  - No further grant until `enable_i` returns.
  - `mask_i`=4'b1010 ⇒ only requesters 1 and 3 are ever granted.
- `reset_i` asserted mid-record:
  - Next cycle `omux_sel_o`=0, `out_we_o`=0, counters=0.
  - After release, requester 0 is granted first.

Source files
------------

// File: rtl/omux_arbiter.sv
// Round-robin arbiter and byte sequencer for the shared omux output bus.
// Grants one requester per whole record, strobes its bytes while the sink has room, then holds off.
module omux_arbiter #(
  parameter int NREQ         = 4,
  parameter int RECORD_BYTES = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic [NREQ-1:0] omux_req_i,
  output logic [NREQ-1:0] omux_sel_o,
  input  logic [7:0]      omux_data_i,
  input  logic            out_full_i,
  output logic            out_we_o,
  output logic [7:0]      out_data_o,
  output logic            out_sor_o,
  output logic            busy_o,
  output logic [31:0]     rec_count_o,
  output logic [15:0]     trunc_count_o
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(RECORD_BYTES) + 1;
  localparam int CW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]     rec_count_q, rec_count_d;
  logic [15:0]     trunc_count_q, trunc_count_d;
  logic            out_we_q;
  logic [7:0]      out_data_q;
  logic            out_sor_q;

  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic [GW:0]     cand_sum;
  logic            strobe;

  assign eligible = omux_req_i & mask_i;

  // Walk offsets from farthest to nearest so the nearest eligible index after last_grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand_sum = {1'b0, last_grant_q} + (GW+1)'(off);
      if (cand_sum >= (GW+1)'(NREQ)) begin
        cand_sum = cand_sum - (GW+1)'(NREQ);
      end
      if (eligible[cand_sum[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rec_count_d   = rec_count_q;
    trunc_count_d = trunc_count_q;
    strobe        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i && pick_valid) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          byte_cnt_d   = '0;
          state_d      = S_XFER;
        end
      end
      S_XFER: begin
        strobe = omux_req_i[grant_q] & ~out_full_i;
        if (!omux_req_i[grant_q]) begin
          // A requester that withdraws before its first byte is not a truncation.
          if (byte_cnt_q != '0 && trunc_count_q != 16'hFFFF) begin
            trunc_count_d = trunc_count_q + 16'd1;
          end
          state_d = S_IDLE;
        end else if (strobe) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == BW'(RECORD_BYTES - 1)) begin
            rec_count_d = rec_count_q + 32'd1;
            gap_cnt_d   = '0;
            state_d     = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + CW'(1);
        if (gap_cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign omux_sel_o[gi] = strobe && (grant_q == GW'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      last_grant_q  <= GW'(NREQ - 1);
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      rec_count_q   <= '0;
      trunc_count_q <= '0;
      out_we_q      <= 1'b0;
      out_data_q    <= '0;
      out_sor_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rec_count_q   <= rec_count_d;
      trunc_count_q <= trunc_count_d;
      out_we_q      <= |omux_sel_o;
      if (strobe) begin
        out_data_q <= omux_data_i;
      end
      out_sor_q     <= strobe && (byte_cnt_q == '0);
    end
  end

  assign out_we_o      = out_we_q;
  assign out_data_o    = out_data_q;
  assign out_sor_o     = out_sor_q;
  assign busy_o        = (state_q != S_IDLE);
  assign rec_count_o   = rec_count_q;
  assign trunc_count_o = trunc_count_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Directed bench for omux_arbiter: requesters are modelled as byte counters whose data is {index, byte}.
module tb_omux_arbiter;
  localparam int NREQ = 4;
  localparam int RB   = 16;
  localparam int GAP  = 2;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            enable = 1'b0;
  logic [NREQ-1:0] mask = '0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] sel;
  logic [7:0]      omux_data;
  logic            full = 1'b0;
  logic            out_we;
  logic [7:0]      out_data;
  logic            out_sor;
  logic            busy;
  logic [31:0]     rec_count;
  logic [15:0]     trunc_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int multi_hot = 0;
  int mon_idx;
  int strobe_cyc[$];
  int strobe_idx[$];
  logic [7:0] out_d[$];
  logic       out_s[$];
  logic [3:0] ptr [NREQ];

  always #5 clk = ~clk;

  omux_arbiter #(.NREQ(NREQ), .RECORD_BYTES(RB), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable), .mask_i(mask),
    .omux_req_i(req), .omux_sel_o(sel), .omux_data_i(omux_data),
    .out_full_i(full), .out_we_o(out_we), .out_data_o(out_data), .out_sor_o(out_sor),
    .busy_o(busy), .rec_count_o(rec_count), .trunc_count_o(trunc_count)
  );

  // Requester model: byte i of a record from requester r is {r, i}; pointer restarts when the request drops.
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset_i || !req[i]) ptr[i] <= 4'd0;
      else if (sel[i]) ptr[i] <= ptr[i] + 4'd1;
    end
  end

  always_comb begin
    omux_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) omux_data = {i[3:0], ptr[i]};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(sel) > 1) multi_hot++;
    if (|sel) begin
      mon_idx = 0;
      for (int i = 0; i < NREQ; i++) if (sel[i]) mon_idx = i;
      strobe_cyc.push_back(cyc);
      strobe_idx.push_back(mon_idx);
    end
    if (out_we) begin
      out_d.push_back(out_data);
      out_s.push_back(out_sor);
    end
  end

  task automatic clear_logs();
    strobe_cyc.delete();
    strobe_idx.delete();
    out_d.delete();
    out_s.delete();
    multi_hot = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req = '0; mask = '0; enable = 1'b0; full = 1'b0;
    step(2);
    reset_i = 1'b0;
    clear_logs();
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (strobe_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req = '1; mask = '1; enable = 1'b1;
    step(2);
    checks++; if (sel !== 4'b0000) begin failures++; $display("FAIL reset_sel got=%b exp=0000", sel); end
    checks++; if (out_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", out_we); end
    checks++; if (out_sor !== 1'b0) begin failures++; $display("FAIL reset_sor got=%b exp=0", out_sor); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rec_count !== 32'd0) begin failures++; $display("FAIL reset_rec got=%0d exp=0", rec_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("FAIL reset_trunc got=%0d exp=0", trunc_count); end
    reset_i = 1'b0;
    req = '0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    do_reset();
    mask = 4'b0001; enable = 1'b1;
    t0 = cyc;
    req = 4'b0001;
    wait_strobes(2*RB, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d strobes exp=%0d", strobe_cyc.size(), 2*RB); return; end
    req = '0;
    step(4);
    checks++; if (strobe_cyc[0] !== t0 + 1) begin failures++; $display("FAIL single_grant_latency got=%0d exp=%0d", strobe_cyc[0], t0 + 1); end
    checks++; if (strobe_cyc[RB-1] - strobe_cyc[0] !== RB - 1) begin failures++; $display("FAIL single_burst_span got=%0d exp=%0d", strobe_cyc[RB-1] - strobe_cyc[0], RB - 1); end
    checks++; if (strobe_cyc[RB] - strobe_cyc[RB-1] !== GAP + 2) begin failures++; $display("FAIL single_regrant_gap got=%0d exp=%0d", strobe_cyc[RB] - strobe_cyc[RB-1], GAP + 2); end
    checks++; if (rec_count !== 32'd2) begin failures++; $display("FAIL single_rec got=%0d exp=2", rec_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("FAIL single_trunc got=%0d exp=0", trunc_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    checks++; if (out_d.size() !== 2*RB) begin failures++; $display("FAIL single_out_count got=%0d exp=%0d", out_d.size(), 2*RB); return; end
    for (int j = 0; j < RB; j++) begin
      checks++; if (out_d[j] !== 8'(j)) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", j, out_d[j], 8'(j)); end
      checks++; if (out_s[j] !== (j == 0)) begin failures++; $display("FAIL single_sor[%0d] got=%b exp=%b", j, out_s[j], (j == 0)); end
    end
    $display("test_single done: %0d bytes", out_d.size());
  endtask

  task automatic test_round_robin();
    bit ok;
    int bad;
    do_reset();
    mask = 4'b1111; enable = 1'b1; req = 4'b1111;
    wait_strobes(5*RB, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got=%0d strobes exp=%0d", strobe_cyc.size(), 5*RB); return; end
    req = '0;
    step(4);
    for (int r = 0; r < 5; r++) begin
      bad = 0;
      for (int j = 0; j < RB; j++) if (strobe_idx[r*RB + j] != r % NREQ) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rr_order rec%0d got=%0d wrong strobes exp=0 (requester %0d)", r, bad, r % NREQ); end
      checks++; if (strobe_cyc[r*RB + RB - 1] - strobe_cyc[r*RB] !== RB - 1) begin failures++; $display("FAIL rr_burst rec%0d got=%0d exp=%0d", r, strobe_cyc[r*RB + RB - 1] - strobe_cyc[r*RB], RB - 1); end
    end
    checks++; if (multi_hot !== 0) begin failures++; $display("FAIL rr_onehot got=%0d exp=0", multi_hot); end
    checks++; if (rec_count !== 32'd5) begin failures++; $display("FAIL rr_rec got=%0d exp=5", rec_count); end
    checks++; if (out_d.size() !== 5*RB) begin failures++; $display("FAIL rr_out_count got=%0d exp=%0d", out_d.size(), 5*RB); return; end
    for (int k = 0; k < 5*RB; k++) begin
      checks++; if (out_d[k] !== 8'(((k / RB) % NREQ) * 16 + (k % RB))) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_d[k], 8'(((k / RB) % NREQ) * 16 + (k % RB))); end
    end
    $display("test_round_robin done: %0d records", rec_count);
  endtask

  task automatic test_full_stall();
    bit ok;
    do_reset();
    mask = 4'b1111; enable = 1'b1; req = 4'b0001;
    wait_strobes(5, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout1 got=%0d exp=5", strobe_cyc.size()); return; end
    full = 1'b1;
    step(3);
    full = 1'b0;
    wait_strobes(RB, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout2 got=%0d exp=%0d", strobe_cyc.size(), RB); return; end
    req = '0;
    step(4);
    checks++; if (strobe_cyc[5] - strobe_cyc[4] !== 4) begin failures++; $display("FAIL stall_pause got=%0d exp=4", strobe_cyc[5] - strobe_cyc[4]); end
    checks++; if (rec_count !== 32'd1) begin failures++; $display("FAIL stall_rec got=%0d exp=1", rec_count); end
    checks++; if (out_d.size() !== RB) begin failures++; $display("FAIL stall_out_count got=%0d exp=%0d", out_d.size(), RB); return; end
    for (int j = 0; j < RB; j++) begin
      checks++; if (out_d[j] !== 8'(j)) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=%h", j, out_d[j], 8'(j)); end
    end
    $display("test_full_stall done");
  endtask

  task automatic test_truncate();
    bit ok;
    do_reset();
    mask = 4'b1111; enable = 1'b1; req = 4'b1100;
    wait_strobes(7, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_timeout1 got=%0d exp=7", strobe_cyc.size()); return; end
    req = 4'b1000;
    step(3);
    checks++; if (trunc_count !== 16'd1) begin failures++; $display("FAIL trunc_count got=%0d exp=1", trunc_count); end
    checks++; if (rec_count !== 32'd0) begin failures++; $display("FAIL trunc_rec_unchanged got=%0d exp=0", rec_count); end
    wait_strobes(7 + RB, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_timeout2 got=%0d exp=%0d", strobe_cyc.size(), 7 + RB); return; end
    req = '0;
    step(4);
    checks++; if (strobe_idx[6] !== 2) begin failures++; $display("FAIL trunc_first_owner got=%0d exp=2", strobe_idx[6]); end
    checks++; if (strobe_idx[7] !== 3) begin failures++; $display("FAIL trunc_next_owner got=%0d exp=3", strobe_idx[7]); end
    checks++; if (strobe_cyc[7] - strobe_cyc[6] !== 3) begin failures++; $display("FAIL trunc_regrant_gap got=%0d exp=3", strobe_cyc[7] - strobe_cyc[6]); end
    checks++; if (rec_count !== 32'd1) begin failures++; $display("FAIL trunc_rec_after got=%0d exp=1", rec_count); end
    checks++; if (trunc_count !== 16'd1) begin failures++; $display("FAIL trunc_count_after got=%0d exp=1", trunc_count); end
    checks++; if (out_d.size() !== 7 + RB) begin failures++; $display("FAIL trunc_out_count got=%0d exp=%0d", out_d.size(), 7 + RB); return; end
    checks++; if (out_d[6] !== 8'h26) begin failures++; $display("FAIL trunc_last_byte got=%h exp=26", out_d[6]); end
    checks++; if (out_d[7] !== 8'h30 || out_s[7] !== 1'b1) begin failures++; $display("FAIL trunc_next_sor got=%h/%b exp=30/1", out_d[7], out_s[7]); end
    $display("test_truncate done");
  endtask

  task automatic test_enable_mask();
    bit ok;
    int bad;
    do_reset();
    mask = 4'b1010; enable = 1'b1; req = 4'b1111;
    wait_strobes(4, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_timeout1 got=%0d exp=4", strobe_cyc.size()); return; end
    enable = 1'b0;
    step(40);
    checks++; if (strobe_cyc.size() !== RB) begin failures++; $display("FAIL en_record_completes got=%0d exp=%0d", strobe_cyc.size(), RB); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_idle_busy got=%b exp=0", busy); end
    checks++; if (rec_count !== 32'd1) begin failures++; $display("FAIL en_rec got=%0d exp=1", rec_count); end
    enable = 1'b1;
    wait_strobes(2*RB, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_timeout2 got=%0d exp=%0d", strobe_cyc.size(), 2*RB); return; end
    req = '0;
    step(4);
    bad = 0;
    for (int j = 0; j < RB; j++) if (strobe_idx[j] != 1) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL en_first_owner got=%0d wrong strobes exp=0 (requester 1)", bad); end
    bad = 0;
    for (int j = RB; j < 2*RB; j++) if (strobe_idx[j] != 3) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL en_second_owner got=%0d wrong strobes exp=0 (requester 3)", bad); end
    checks++; if (rec_count !== 32'd2) begin failures++; $display("FAIL en_rec_after got=%0d exp=2", rec_count); end
    $display("test_enable_mask done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    mask = 4'b1111; enable = 1'b1; req = 4'b0111;
    wait_strobes(RB + 5, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=%0d exp=%0d", strobe_cyc.size(), RB + 5); return; end
    checks++; if (rec_count !== 32'd1) begin failures++; $display("FAIL rmid_rec_before got=%0d exp=1", rec_count); end
    reset_i = 1'b1;
    step(1);
    checks++; if (sel !== 4'b0000) begin failures++; $display("FAIL rmid_sel got=%b exp=0000", sel); end
    checks++; if (out_we !== 1'b0) begin failures++; $display("FAIL rmid_we got=%b exp=0", out_we); end
    checks++; if (rec_count !== 32'd0) begin failures++; $display("FAIL rmid_rec got=%0d exp=0", rec_count); end
    checks++; if (trunc_count !== 16'd0) begin failures++; $display("FAIL rmid_trunc got=%0d exp=0", trunc_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    reset_i = 1'b0;
    clear_logs();
    wait_strobes(1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_regrant_timeout got=%0d exp=1", strobe_cyc.size()); return; end
    checks++; if (strobe_idx[0] !== 0) begin failures++; $display("FAIL rmid_first_grant got=%0d exp=0", strobe_idx[0]); end
    step(2);
    checks++; if (out_d.size() < 1) begin failures++; $display("FAIL rmid_out_count got=%0d exp>=1", out_d.size()); return; end
    checks++; if (out_d[0] !== 8'h00 || out_s[0] !== 1'b1) begin failures++; $display("FAIL rmid_first_byte got=%h/%b exp=00/1", out_d[0], out_s[0]); end
    req = '0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_truncate();
    test_enable_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
